// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared constants and FSM encoding for the PHY receive deserializer
package phy_pkg;

  // Idle / alignment character sent by the transmit PHY
  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

  // Width of the round-robin lane tag
  localparam int LANE_W = 2;

  // Receive alignment FSM encoding
  typedef logic [1:0] rx_state_t;
  localparam rx_state_t HUNT   = 2'd0;
  localparam rx_state_t LOCK   = 2'd1;
  localparam rx_state_t ACTIVE = 2'd2;

endpackage

// File: rtl/rx_shift_align.sv
// rtl/rx_shift_align.sv - serial shift register, bit phase counter and comma detect
module rx_shift_align
  import phy_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_DEFAULT
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  input  logic       bit_clr_i,
  output logic [7:0] sr_o,
  output logic       comma_o,
  output logic       boundary_o
);

  logic [7:0] sr_q;
  logic [2:0] bit_cnt_q;
  logic [2:0] bit_cnt_d;

  // Bit phase restarts at a HUNT match so the next 8 bits form the first aligned byte
  always_comb begin
    bit_cnt_d = bit_cnt_q + 3'd1;
    if (bit_clr_i) begin
      bit_cnt_d = 3'd0;
    end
  end

  // Shift in one bit per cycle, MSB first, regardless of FSM state
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else begin
      sr_q      <= {sr_q[6:0], data_in};
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign sr_o       = sr_q;
  assign comma_o    = (sr_q == COMMA);
  assign boundary_o = (bit_cnt_q == 3'd7);

endmodule

// File: rtl/phy_rx_deser.sv
// rtl/phy_rx_deser.sv - comma-aligned serial-to-byte receiver; PHY_RX_LANE_TAG_EN enables lane tagging
module phy_rx_deser
  import phy_pkg::*;
#(
  parameter logic [7:0]  COMMA      = COMMA_DEFAULT,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [7:0]        data_out,
  output logic              valid_out,
  output logic              byte_strobe,
  output logic [LANE_W-1:0] lane,
  output logic              active
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  rx_state_t  state_q;
  rx_state_t  state_d;
  logic [3:0] bc_cnt_q;
  logic [3:0] bc_cnt_d;
  logic [3:0] bc_inc;
  logic [7:0] sr;
  logic       is_comma;
  logic       boundary;
  logic       bit_clr;
  logic       slot;
  logic [7:0] data_q;
  logic       valid_q;
  logic       strobe_q;

  rx_shift_align #(
    .COMMA (COMMA)
  ) u_align (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .bit_clr_i  (bit_clr),
    .sr_o       (sr),
    .comma_o    (is_comma),
    .boundary_o (boundary)
  );

  assign bc_inc = bc_cnt_q + 4'd1;
  assign slot   = (state_q == ACTIVE) && boundary;

  // Alignment FSM: any-offset comma search, then count boundary-aligned commas
  always_comb begin
    state_d  = state_q;
    bc_cnt_d = bc_cnt_q;
    bit_clr  = 1'b0;
    case (state_q)
      HUNT: begin
        if (is_comma) begin
          bit_clr  = 1'b1;
          bc_cnt_d = 4'd1;
          state_d  = (LOCK_CNT == 4'd1) ? ACTIVE : LOCK;
        end
      end
      LOCK: begin
        if (boundary) begin
          if (is_comma) begin
            bc_cnt_d = bc_inc;
            if (bc_inc == LOCK_CNT) begin
              state_d = ACTIVE;
            end
          end else begin
            bc_cnt_d = 4'd0;
            state_d  = HUNT;
          end
        end
      end
      default: begin
        // ACTIVE is only left through reset: data is indistinguishable from misalignment
      end
    endcase
  end

  // FSM state and comma counter
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q  <= HUNT;
      bc_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      bc_cnt_q <= bc_cnt_d;
    end
  end

  // Byte slot outputs: data holds between slots, strobe and valid pulse for one cycle
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= slot;
      valid_q  <= slot && !is_comma;
      if (slot) begin
        data_q <= sr;
      end
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = (state_q == ACTIVE);

`ifdef PHY_RX_LANE_TAG_EN
  logic [LANE_W-1:0] ptr_q;
  logic [LANE_W-1:0] lane_q;

  // Round-robin lane tag, restarted at lane 0 on every entry to ACTIVE
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      ptr_q  <= '0;
      lane_q <= '0;
    end else if ((state_q != ACTIVE) && (state_d == ACTIVE)) begin
      ptr_q <= '0;
    end else if (slot) begin
      lane_q <= ptr_q;
      ptr_q  <= ptr_q + 1'b1;
    end
  end

  assign lane = lane_q;
`else
  assign lane = '0;
`endif

endmodule

// File: tb/tb_phy_rx_deser.sv
// tb/tb_phy_rx_deser.sv - directed self-checking bench for phy_rx_deser
module tb_phy_rx_deser;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       din   = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic [1:0] lane;
  logic       active;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int         n_strb = 0;
  int         st_cyc   [64];
  logic [7:0] st_data  [64];
  logic       st_valid [64];
  logic [1:0] st_lane  [64];
  int         rise_cyc = -1;
  logic       act_prev = 1'b0;

  phy_rx_deser #(
    .LOCK_COUNT (4)
  ) dut (
    .clk_32f     (clk),
    .reset       (rst_n),
    .data_in     (din),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .lane        (lane),
    .active      (active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every strobe and every rising edge of active, sampled mid-cycle
  always @(negedge clk) begin
    if (byte_strobe && n_strb < 64) begin
      st_cyc[n_strb]   = cyc;
      st_data[n_strb]  = data_out;
      st_valid[n_strb] = valid_out;
      st_lane[n_strb]  = lane;
      n_strb           = n_strb + 1;
    end
    if (active && !act_prev) rise_cyc = cyc;
    act_prev = active;
  end

  function automatic logic [1:0] lane_exp(input int i);
`ifdef PHY_RX_LANE_TAG_EN
    return 2'(i % 4);
`else
    return 2'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int         base;
    int         c_end;
    logic [7:0] pay   [5];
    logic       vexp  [5];
    pay  = '{8'h55, 8'hBC, 8'hA3, 8'h0F, 8'h77};
    vexp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_strobe", byte_strobe, 1'b0);
    chk("rst_lane", lane, 2'd0);
    chk("rst_active", active, 1'b0);
    rst_n = 1'b1;

    // Four commas lock, then five bytes with a comma slot and a lane wrap
    repeat (4) send_byte(8'hBC);
    c_end = cyc;
    chk("no_strobe_before_lock", n_strb, 0);
    chk("active_not_yet", active, 1'b0);
    base = n_strb;
    for (int i = 0; i < 5; i++) send_byte(pay[i]);
    send_byte(8'hBC);
    chk("lock_rise_cyc", rise_cyc, c_end + 1);
    chk("strobe_count", n_strb - base, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("slot%0d_cyc", i), st_cyc[base+i], rise_cyc + 8 + 8 * i);
      chk($sformatf("slot%0d_data", i), st_data[base+i], pay[i]);
      chk($sformatf("slot%0d_valid", i), st_valid[base+i], vexp[i]);
      chk($sformatf("slot%0d_lane", i), st_lane[base+i], lane_exp(i));
    end
    chk("data_hold", data_out, 8'h77);
    chk("strobe_low_between", byte_strobe, 1'b0);
    chk("active_stays", active, 1'b1);

    // Lock at a 3-bit offset
    do_reset();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    repeat (4) send_byte(8'hBC);
    c_end = cyc;
    base  = n_strb;
    send_byte(8'h81);
    send_byte(8'hBC);
    chk("off_rise_cyc", rise_cyc, c_end + 1);
    chk("off_strobe_count", n_strb - base, 1);
    chk("off_data", st_data[base], 8'h81);
    chk("off_valid", st_valid[base], 1'b1);
    chk("off_lane", st_lane[base], 2'd0);

    // Non-comma during LOCK aborts back to HUNT
    do_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h12);
    chk("abort_inactive", active, 1'b0);
    repeat (4) send_byte(8'hBC);
    c_end = cyc;
    base  = n_strb;
    send_byte(8'h34);
    repeat (4) send_bit(1'b1);
    chk("abort_rise_cyc", rise_cyc, c_end + 1);
    chk("abort_strobe_count", n_strb - base, 1);
    chk("abort_data", st_data[base], 8'h34);

    // Asynchronous reset mid-byte while ACTIVE
    chk("pre_rst_data", data_out, 8'h34);
    chk("pre_rst_active", active, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("async_data", data_out, 8'h00);
    chk("async_valid", valid_out, 1'b0);
    chk("async_strobe", byte_strobe, 1'b0);
    chk("async_lane", lane, 2'd0);
    chk("async_active", active, 1'b0);
    rst_n = 1'b1;
    repeat (3) send_byte(8'hBC);
    chk("relock_3_commas", active, 1'b0);
    send_byte(8'hBC);
    chk("relock_4th_shifted", active, 1'b0);
    send_bit(1'b0);
    chk("relock_active", active, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
